// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encoding, data width, default divider.
// The optional even-parity helper is used only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int UART_DATA_BITS        = 8;
  localparam int UART_BAUD_DIV_DEFAULT = 868;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_START  = S_START,
    ST_DATA   = S_DATA,
    ST_PARITY = S_PARITY,
    ST_STOP   = S_STOP
  } uart_state_e;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..BAUD_DIV-1 while enabled, held at zero by clr_i,
// and flags the last cycle of each bit period with bit_end_o.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = UART_BAUD_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic bit_end_o
);

  localparam int            CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear, wrap at end of bit, or increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// Pops bytes from the TX FIFO and serialises them as 8N1/8N2 frames on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1/8E2).
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int BAUD_DIV  = UART_BAUD_DIV_DEFAULT,
  parameter int STOP_BITS = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tx_en,
  input  logic                      fifo_empty,
  input  logic [UART_DATA_BITS-1:0] fifo_data,
  output logic                      fifo_read,
  output logic                      tx,
  output logic                      busy
);

  localparam int            IW        = $clog2(UART_DATA_BITS);
  localparam logic [IW-1:0] DATA_LAST = IW'(UART_DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  uart_state_e               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]             bit_idx_q, bit_idx_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      launch_s;
  logic                      can_pop_s;
  logic                      bit_end_s;
`ifdef UART_TX_PARITY_EN
  logic                      par_q, par_d;
`endif

  uart_baud_cnt #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q == ST_IDLE),
    .bit_end_o (bit_end_s)
  );

  assign can_pop_s = tx_en && !fifo_empty;

  // Frame sequencing; a launch from IDLE or the last stop cycle overrides the per-state result.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    launch_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d      = 1'b1;
        busy_d    = 1'b0;
        bit_idx_d = '0;
        launch_s  = can_pop_s;
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end else begin
          tx_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (!bit_end_s) begin
          tx_d = shift_q[0];
        end else if (bit_idx_q == DATA_LAST) begin
          bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
          state_d   = ST_PARITY;
          tx_d      = par_q;
`else
          state_d   = ST_STOP;
          tx_d      = 1'b1;
`endif
        end else begin
          bit_idx_d = bit_idx_q + IW'(1);
          shift_d   = shift_q >> 1;
          tx_d      = shift_q[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end_s) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end else begin
          tx_d = par_q;
        end
      end
`endif
      ST_STOP: begin
        tx_d = 1'b1;
        if (!bit_end_s) begin
          bit_idx_d = bit_idx_q;
        end else if (bit_idx_q != STOP_LAST) begin
          bit_idx_d = bit_idx_q + IW'(1);
        end else if (can_pop_s) begin
          launch_s = 1'b1;
        end else begin
          bit_idx_d = '0;
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        tx_d      = 1'b1;
        busy_d    = 1'b0;
        bit_idx_d = '0;
      end
    endcase
    if (launch_s) begin
      state_d   = ST_START;
      shift_d   = fifo_data;
      bit_idx_d = '0;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
    end else begin
      state_d = state_d;
    end
  end

  // Main state and output registers; tx is forced high by reset at any time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is taken from the whole byte at launch, since the shifter consumes it.
  always_comb begin
    if (launch_s) begin
      par_d = even_parity(fifo_data);
    end else begin
      par_d = par_q;
    end
  end

  // Parity bit register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  // The pop strobe must stay low while reset is held even though IDLE could launch.
  assign fifo_read = launch_s && rst;
  assign tx        = tx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Scoreboard bench for uart_tx_drain (BAUD_DIV=4); a second instance covers STOP_BITS=2.
`timescale 1ns/1ps
module tb_uart_tx_drain;

  localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = 10 + PB;
  localparam int FL = NB * BD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_en = 1'b0;
  logic       fifo_empty, fifo_read, tx, busy;
  logic [7:0] fifo_data;

  logic [7:0] mem [16];
  int         wr_p = 0, rd_p = 0, pops = 0;
  int         cyc = 0, last_pop = -100;
  logic       mon_en = 1'b0;
  logic [7:0] exp_q [$];
  int         busy_runs [$];
  int         brun = 0;
  int         n_vec = 0, n_err = 0;

  logic       d2_req = 1'b0, d2_popped = 1'b0, d2_done = 1'b0;
  logic       d2_empty, d2_read, tx2, busy2;
  logic       q2 [$];

  assign fifo_empty = (wr_p == rd_p);
  assign fifo_data  = mem[rd_p[3:0]];
  assign d2_empty   = !(d2_req && !d2_popped);

  uart_tx_drain #(.BAUD_DIV(BD), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_read(fifo_read), .tx(tx), .busy(busy)
  );

  uart_tx_drain #(.BAUD_DIV(BD), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .tx_en(1'b1), .fifo_empty(d2_empty),
    .fifo_data(8'h5A), .fifo_read(d2_read), .tx(tx2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] frame_of(input logic [7:0] b);
    logic [NB-1:0] f;
    f = '0;
    f[8:1] = b;
    if (PB == 1) f[9] = ^b;
    f[NB-1] = 1'b1;
    return f;
  endfunction

  task automatic push(input logic [7:0] b, input logic exp_it);
    mem[wr_p[3:0]] = b;
    wr_p++;
    if (exp_it) exp_q.push_back(b);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_timeout"}, (n < budget), 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_runs(input string nm, input int len);
    chk({nm, "_busy_runs"}, busy_runs.size(), 1);
    if (busy_runs.size() > 0) chk({nm, "_busy_len"}, busy_runs[0], len);
    busy_runs.delete();
  endtask

  // FIFO model: pop on the strobe edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_read) begin
      rd_p <= rd_p + 1;
      pops <= pops + 1;
    end
    if (d2_read) d2_popped <= 1'b1;
  end

  // Pop legality and timestamp for launch latency.
  always @(negedge clk) begin
    if (fifo_read) begin
      chk("pop_while_empty", fifo_empty, 1'b0);
      last_pop <= cyc;
    end
  end

  // Busy run lengths.
  always @(negedge clk) begin
    if (busy) brun <= brun + 1;
    else if (brun != 0) begin
      busy_runs.push_back(brun);
      brun <= 0;
    end
  end

  // Frame monitor: every bit sampled BD times, compared against the scoreboard.
  always begin : mon
    logic [NB-1:0] bits;
    logic          stable;
    logic [7:0]    eb;
    @(negedge clk);
    if (mon_en && rst && tx == 1'b0) begin
      chk("launch_latency", cyc - last_pop, 1);
      stable = 1'b1;
      bits   = '0;
      for (int b = 0; b < NB; b++) begin
        for (int c = 0; c < BD; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (c == 0) bits[b] = tx;
          else if (tx !== bits[b]) stable = 1'b0;
        end
      end
      chk("bit_hold", stable, 1'b1);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_frame: got %0h expected no frame", bits);
      end else begin
        eb = exp_q.pop_front();
        chk("frame", bits, frame_of(eb));
      end
    end
  end

  // Two-stop-bit instance: 0x5A ends with data bit 0, then 8 high stop cycles.
  always @(negedge clk) begin
    if (busy2) q2.push_back(tx2);
    else if (q2.size() != 0) begin
      logic ok;
      ok = 1'b1;
      for (int i = q2.size() - 8; i < q2.size(); i++) ok &= q2[i];
      chk("stop2_len", q2.size(), 44 + 4 * PB);
      chk("stop2_high", ok, 1'b1);
      chk("stop2_prev", q2[q2.size() - 9], 1'b0);
      q2.delete();
      d2_done <= 1'b1;
    end
  end

  initial begin
    int p0;
    int bad;
    // Reset held with a byte available and tx_en high: no pop.
    tx_en = 1'b1;
    push(8'h81, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_read", fifo_read, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (12) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_read", fifo_read, 1'b0);
    chk("midrst_popped", pops, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("idle_after_rst", bad, 0);
    busy_runs.delete();
    mon_en = 1'b1;
    d2_req = 1'b1;

    // Single byte 0xA5.
    p0 = pops;
    push(8'hA5, 1'b1);
    wait_idle("a5", 200);
    chk("a5_pops", pops - p0, 1);
    chk_runs("a5", FL);
    chk("a5_idle_tx", tx, 1'b1);

    // Back-to-back 0x00, 0xFF, 0x55.
    tx_en = 1'b0;
    p0 = pops;
    push(8'h00, 1'b1);
    push(8'hFF, 1'b1);
    push(8'h55, 1'b1);
    @(posedge clk); #1 tx_en = 1'b1;
    wait_idle("b2b", 500);
    chk("b2b_pops", pops - p0, 3);
    chk_runs("b2b", 3 * FL);

    // tx_en gating.
    tx_en = 1'b0;
    p0 = pops;
    push(8'h3C, 1'b1);
    push(8'h42, 1'b0);
    repeat (20) @(negedge clk);
    chk("gate_nopop", pops - p0, 0);
    chk("gate_tx", tx, 1'b1);
    @(posedge clk); #1 tx_en = 1'b1;
    @(negedge clk);
    chk("gate_pop_now", fifo_read, 1'b1);
    repeat (8) @(posedge clk);
    #1 tx_en = 1'b0;
    wait_idle("gate", 200);
    repeat (20) @(negedge clk);
    chk("gate_one_pop", pops - p0, 1);
    chk("gate_left", fifo_empty, 1'b0);
    chk_runs("gate", FL);
    exp_q.push_back(8'h42);
    tx_en = 1'b1;
    wait_idle("gate2", 200);
    chk_runs("gate2", FL);

    // Parity boundary bytes (plain frames when parity is off).
    push(8'h07, 1'b1);
    wait_idle("b07", 200);
    chk_runs("b07", FL);
    push(8'h03, 1'b1);
    wait_idle("b03", 200);
    chk_runs("b03", FL);

    // Two-stop-bit instance completion.
    bad = 0;
    while (!d2_done && bad < 300) begin
      @(negedge clk);
      bad++;
    end
    chk("stop2_done", d2_done, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
